// File: rtl/rmt_cookie_pkg.sv
// Shared cookie constants and checker state encoding; also imported by the cookie generator.
// No logic, no latency. No backpressure.
package rmt_cookie_pkg;

    localparam int          COOKIE_LEN  = 32;
    localparam logic [31:0] COOKIE_BASE = 32'hf1ec234d;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } chk_state_t;

endpackage

// File: rtl/cookie_checker_if.sv
// AXI-Stream bundle carried between the control path and the cookie checker.
// Wires only: no latency. Backpressure via tready.
interface cookie_checker_if #(
    parameter int DW = 256,
    parameter int UW = 128
) ();
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0]   tuser;
    logic            tvalid;
    logic            tlast;
    logic            tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input  tready);
    modport slave  (input  tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/cookie_window.sv
// Tracks the current and (with COOKIE_GRACE_EN) previous cookie generation from c_val.
// Latency: 1 cycle from c_val change to register update. No backpressure.
module cookie_window
    import rmt_cookie_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COOKIE_LEN-1:0] c_val,
`ifdef COOKIE_GRACE_EN
    output logic [COOKIE_LEN-1:0] prev_ck,
`endif
    output logic [COOKIE_LEN-1:0] cur_ck
);

`ifdef COOKIE_GRACE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ck  <= COOKIE_BASE;
            prev_ck <= COOKIE_BASE;
        end else if (c_val != cur_ck) begin
            prev_ck <= cur_ck;
            cur_ck  <= c_val;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ck <= COOKIE_BASE;
        end else if (c_val != cur_ck) begin
            cur_ck <= c_val;
        end
    end
`endif

endmodule

// File: rtl/cookie_checker.sv
// Forwards control packets whose first-beat cookie matches the window (prev too if COOKIE_GRACE_EN); drops others whole.
// Latency: 1 cycle through a single output register slice, 1 beat/cycle sustained.
// Backpressure: s_axis_tready = ~m_axis_tvalid | m_axis_tready, forced high while discarding a packet.
module cookie_checker
    import rmt_cookie_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int COOKIE_OFFSET        = 224
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COOKIE_LEN-1:0] c_val,
    cookie_checker_if.slave       s_axis,
    cookie_checker_if.master      m_axis,
    output logic [31:0]           pkt_pass_cnt,
    output logic [31:0]           pkt_drop_cnt
);

    chk_state_t            state;
    logic [COOKIE_LEN-1:0] cur_ck;
    logic [COOKIE_LEN-1:0] rx_ck;
    logic                  ck_hit;
    logic                  s_rdy;
    logic                  s_acc;
    logic                  first_acc;
    logic                  load;

`ifdef COOKIE_GRACE_EN
    logic [COOKIE_LEN-1:0] prev_ck;

    cookie_window u_window (
        .clk     (clk),
        .rst     (rst),
        .c_val   (c_val),
        .prev_ck (prev_ck),
        .cur_ck  (cur_ck)
    );

    assign ck_hit = (rx_ck == cur_ck) || (rx_ck == prev_ck);
`else
    cookie_window u_window (
        .clk    (clk),
        .rst    (rst),
        .c_val  (c_val),
        .cur_ck (cur_ck)
    );

    assign ck_hit = (rx_ck == cur_ck);
`endif

    // Window registers are compared as they stand, so a same-cycle c_val change affects the next packet only.
    assign rx_ck     = s_axis.tdata[COOKIE_OFFSET +: COOKIE_LEN];
    assign s_rdy     = (state == DROP) | ~m_axis.tvalid | m_axis.tready;
    assign s_acc     = s_axis.tvalid & s_rdy;
    assign first_acc = s_acc & (state == IDLE);
    assign load      = s_acc & ((state == PASS) | ((state == IDLE) & ck_hit));

    assign s_axis.tready = s_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (s_acc && !s_axis.tlast) begin
                        state <= ck_hit ? PASS : DROP;
                    end
                end
                PASS, DROP: begin
                    if (s_acc && s_axis.tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tkeep  <= '0;
            m_axis.tuser  <= '0;
            m_axis.tlast  <= 1'b0;
        end else if (load) begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= s_axis.tdata;
            m_axis.tkeep  <= s_axis.tkeep;
            m_axis.tuser  <= s_axis.tuser;
            m_axis.tlast  <= s_axis.tlast;
        end else if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_pass_cnt <= '0;
            pkt_drop_cnt <= '0;
        end else if (first_acc) begin
            if (ck_hit && (pkt_pass_cnt != '1)) begin
                pkt_pass_cnt <= pkt_pass_cnt + 32'd1;
            end
            if (!ck_hit && (pkt_drop_cnt != '1)) begin
                pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_cookie_checker.sv
// Scoreboarded bench for cookie_checker: directed scenarios, then randomized packets against a window model.
// Honours COOKIE_GRACE_EN the same way as the design.
module tb_cookie_checker;
    import rmt_cookie_pkg::*;

    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int KW  = DW / 8;
    localparam int OFS = 224;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        int            acc;
        bit            lat;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_val;
    logic [31:0] pass_cnt;
    logic [31:0] drop_cnt;

    cookie_checker_if #(.DW(DW), .UW(UW)) s_if ();
    cookie_checker_if #(.DW(DW), .UW(UW)) m_if ();

    cookie_checker #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .COOKIE_OFFSET        (OFS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .c_val        (c_val),
        .s_axis       (s_if.slave),
        .m_axis       (m_if.master),
        .pkt_pass_cnt (pass_cnt),
        .pkt_drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    beat_t exp_q[$];

    // Reference model of the cookie window and packet counters
    logic [31:0] m_cur, m_prev;
    int          exp_pass, exp_drop;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit model_accepts(input logic [31:0] ck);
`ifdef COOKIE_GRACE_EN
        return (ck == m_cur) || (ck == m_prev);
`else
        return (ck == m_cur);
`endif
    endfunction

    function automatic void model_cval(input logic [31:0] v);
        if (v != m_cur) begin
            m_prev = m_cur;
            m_cur  = v;
        end
    endfunction

    // Called at posedge+1; leaves a full cycle so the window settles before the next packet
    task automatic set_cval(input logic [31:0] v);
        c_val = v;
        model_cval(v);
        @(posedge clk); #1;
    endtask

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = ($urandom_range(0, 3) != 0);
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks stall stability
    initial begin
        bit            stall;
        logic [DW-1:0] sd;
        beat_t         e;
        stall = 0;
        sd    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0;
            end else begin
                if (stall) begin
                    chk("stall_vld", DW'(m_if.tvalid), DW'(1));
                    chk("stall_dat", m_if.tdata, sd);
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat actual=%h required=none", m_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", m_if.tdata, e.d);
                        chk("out_keep", DW'(m_if.tkeep), DW'(e.k));
                        chk("out_user", DW'(m_if.tuser), DW'(e.u));
                        chk("out_last", DW'(m_if.tlast), DW'(e.l));
                        if (e.lat) chk("latency", DW'(cyc - e.acc), DW'(1));
                    end
                end
                stall = m_if.tvalid && !m_if.tready;
                sd    = m_if.tdata;
            end
        end
    end

    function automatic beat_t make_beat(input logic [31:0] ck, input bit first, input bit last);
        beat_t b;
        for (int j = 0; j < DW / 32; j++) b.d[j*32 +: 32] = $urandom;
        for (int j = 0; j < UW / 32; j++) b.u[j*32 +: 32] = $urandom;
        b.k = $urandom;
        if (first) b.d[OFS +: 32] = ck;
        b.l   = last;
        b.acc = 0;
        b.lat = 0;
        return b;
    endfunction

    // Entered and left at posedge+1. cv_first changes c_val together with the first beat,
    // valid only when the first beat is guaranteed to be taken on the next edge.
    task automatic send_pkt(input logic [31:0] ck, input int n, input bit lat, input bit gaps,
                            input bit cv_mid, input bit cv_first, input logic [31:0] cv_new);
        bit    pass;
        beat_t b;
        int    w;
        pass = model_accepts(ck);
        if (pass) exp_pass++;
        else      exp_drop++;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                s_if.tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            if (i == 0 && cv_first) begin
                c_val = cv_new;
                model_cval(cv_new);
            end
            if (i > 0 && cv_mid && $urandom_range(0, 3) == 0) begin
                c_val = ($urandom_range(0, 1) == 0) ? m_prev : $urandom;
                model_cval(c_val);
            end
            b = make_beat(ck, i == 0, i == n - 1);
            s_if.tdata  = b.d;
            s_if.tkeep  = b.k;
            s_if.tuser  = b.u;
            s_if.tlast  = b.l;
            s_if.tvalid = 1'b1;
            w = 0;
            forever begin
                @(negedge clk);
                if (!pass && i > 0 && w == 0) chk("drop_rdy", DW'(s_if.tready), DW'(1));
                if (s_if.tready) break;
                w++;
                if (w > 200) begin
                    total++;
                    bad++;
                    $display("FAIL s_ready_timeout actual=0 required=1");
                    break;
                end
                @(posedge clk); #1;
            end
            if (pass) begin
                b.acc = cyc;
                b.lat = lat;
                exp_q.push_back(b);
            end
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain_and_count();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        chk("pass_cnt", DW'(pass_cnt), DW'(exp_pass));
        chk("drop_cnt", DW'(drop_cnt), DW'(exp_drop));
    endtask

    task automatic model_reset();
        m_cur    = COOKIE_BASE;
        m_prev   = COOKIE_BASE;
        exp_pass = 0;
        exp_drop = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        beat_t b;
        logic [31:0] ck;
        rst         = 1'b1;
        c_val       = COOKIE_BASE;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", DW'(m_if.tvalid), DW'(0));
        chk("rst_tdata", m_if.tdata, '0);
        chk("rst_pass", DW'(pass_cnt), DW'(0));
        chk("rst_drop", DW'(drop_cnt), DW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Matching 3-beat packet, latency checked
        rdy_mode = 0;
        send_pkt(COOKIE_BASE, 3, 1, 0, 0, 0, '0);
        drain_and_count();

        // Mismatching 4-beat packet
        send_pkt(32'hdeadbeef, 4, 0, 0, 0, 0, '0);
        drain_and_count();

        // One rollover: only the grace window keeps the old cookie
        set_cval(32'h12345678);
        send_pkt(COOKIE_BASE, 2, 1, 0, 0, 0, '0);
        drain_and_count();

        // Two rollovers: the base cookie has left the window
        set_cval(COOKIE_BASE);
        set_cval(32'h12345678);
        set_cval(32'h0badf00d);
        send_pkt(COOKIE_BASE, 2, 0, 0, 0, 0, '0);
        drain_and_count();

        // c_val changes on the first-beat edge: verdict uses the old window
        send_pkt(32'h0badf00d, 2, 1, 0, 0, 1, 32'h55aa55aa);
        drain_and_count();
        send_pkt(32'h0badf00d, 1, 0, 0, 0, 0, '0);
        drain_and_count();

        // 5-beat packet with a 5-cycle output stall mid-packet
        set_cval(COOKIE_BASE);
        fork
            send_pkt(COOKIE_BASE, 5, 0, 0, 0, 0, '0);
            begin
                repeat (2) @(posedge clk);
                rdy_mode = 2;
                repeat (5) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain_and_count();

        // Reset while beat 2 of a passing packet is presented and beat 1 is held at the output
        rdy_mode = 2;
        @(posedge clk); #1;
        b = make_beat(COOKIE_BASE, 1, 0);
        s_if.tdata  = b.d;
        s_if.tkeep  = b.k;
        s_if.tuser  = b.u;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        @(posedge clk); #1;
        b = make_beat(COOKIE_BASE, 0, 0);
        s_if.tdata = b.d;
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tvalid", DW'(m_if.tvalid), DW'(0));
        @(posedge clk); #1;
        rst         = 1'b0;
        s_if.tvalid = 1'b0;
        rdy_mode    = 0;
        model_reset();
        c_val = COOKIE_BASE;
        @(posedge clk); #1;
        send_pkt(COOKIE_BASE, 2, 1, 0, 0, 0, '0);
        drain_and_count();

        // Randomized traffic with backpressure, gaps and rollovers
        rdy_mode = 1;
        for (int p = 0; p < 60; p++) begin
            case ($urandom_range(0, 3))
                0, 3:    ck = m_cur;
                1:       ck = m_prev;
                default: ck = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) set_cval($urandom);
            send_pkt(ck, $urandom_range(1, 6), 0, 1, 1, 0, '0);
            if ($urandom_range(0, 3) == 0) begin
                s_if.tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain_and_count();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cookie_checker.md
# cookie_checker

Authenticates control packets against the rolling cookie. The block sits directly downstream of the cookie generator and consumes its `c_val` output. It extracts a 32-bit cookie from the first beat of each AXI-Stream packet on the control path. Packets whose cookie matches the current, or optionally the previous, cookie generation are forwarded to the reconfiguration logic; all other packets are dropped whole.

## Interface
Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- COOKIE_OFFSET, 224, LSB position of the cookie in first-beat tdata; must be ≤ C_S_AXIS_DATA_WIDTH-32.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- c_val  in  32  current cookie from the generator.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  input stream.
- s_axis_tready  out  1  input ready.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  output stream.
- m_axis_tready  in  1  output ready.
- pkt_pass_cnt  out  32  saturating count of forwarded packets.
- pkt_drop_cnt  out  32  saturating count of dropped packets.

## Operation
- Cookie window: registers `cur_ck` and `prev_ck`, both reset to COOKIE_BASE (32'hf1ec234d).
  - When `c_val != cur_ck`: `prev_ck <= cur_ck` and `cur_ck <= c_val`.
  - Otherwise both registers hold.
- Match rule: first-beat field `tdata[COOKIE_OFFSET +: 32]` is compared against the register values before any same-cycle window update.
- FSM states:
  - IDLE: waiting for a first beat.
  - PASS: forwarding the remainder of an accepted packet.
  - DROP: discarding the remainder of a rejected packet.
- Transitions:
  - An accepted beat in IDLE is a first beat.
  - On a match, the beat is forwarded. Go to PASS unless the beat has tlast set.
  - On a mismatch, the beat is discarded. Go to DROP unless the beat has tlast set.
  - An accepted tlast beat in PASS or DROP returns the FSM to IDLE.
  - A single-beat packet stays in IDLE.
- Counters:
  - pass or drop count increments by 1 on the first-beat decision.
  - Both counters saturate at 32'hffffffff.
- Forwarded beats pass through unmodified: tdata, tkeep, tuser and tlast are unchanged.

## Timing
- Output stage is a single register slice.
  - Latency from s_axis handshake to m_axis_tvalid: 1 cycle.
  - Sustained throughput: 1 beat/cycle.
- `s_axis_tready = ~m_axis_tvalid | m_axis_tready` in IDLE and PASS.
  - A mismatching first beat in IDLE uses the same ready rule but is never loaded into the output register.
  - In DROP, s_axis_tready is held at 1 and beats are never loaded.
- m_axis payload and tvalid remain stable while `m_axis_tvalid & ~m_axis_tready`.
- Reset values:
  - m_axis_tvalid=0, m_axis payload=0.
  - Counters=0.
  - FSM=IDLE.
  - cur_ck=prev_ck=COOKIE_BASE.
- Reset mid-packet:
  - Any held output beat is lost.
  - After reset, the first accepted beat is treated as a first beat.
- Window update and first-beat decision in the same cycle: the decision uses the old values, and the update still takes effect.
- c_val changes while in PASS or DROP: the verdict for the current packet is unaffected.

## Configuration
- Macro: COOKIE_GRACE_EN.
- Defined: a match against either `cur_ck` or `prev_ck` is accepted. This tolerates a cookie rollover while the packet is in flight.
- Undefined: only `cur_ck` is accepted. `prev_ck` is not implemented.

## Structure
- Shared package `rmt_cookie_pkg`:
  - COOKIE_BASE.
  - COOKIE_LEN (32).
  - FSM state typedef (IDLE, PASS, DROP).
  - The package is also imported by the cookie generator, so reset values match.
- One sub-module, `cookie_window`:
  - Holds the cur/prev tracking registers.
  - Exposes `cur_ck` and `prev_ck`; `prev_ck` only when COOKIE_GRACE_EN is defined.
- FSM, output slice and counters live in `cookie_checker`.

## Test plan
- Reset, c_val=32'hf1ec234d, then a 3-beat packet with cookie 32'hf1ec234d → 3 identical output beats, each 1 cycle after input; pkt_pass_cnt=1.
- 4-beat packet with cookie 32'hdeadbeef → no m_axis_tvalid; s_axis_tready=1 for all 4 beats; pkt_drop_cnt=1.
- c_val changes to 32'h12345678, then a 2-beat packet with cookie 32'hf1ec234d → forwarded with COOKIE_GRACE_EN; dropped without it.
- c_val changes twice (32'h12345678, then 32'h0badf00d), then a packet with cookie 32'hf1ec234d → dropped in both configurations.
- Passing 5-beat packet with m_axis_tready low for 5 cycles mid-packet → output beat stable while stalled; all 5 beats delivered in order with no duplicates.
- rst asserted on beat 2 of a 4-beat packet → m_axis_tvalid=0 next cycle; the next packet, with cookie 32'hf1ec234d, is forwarded and pkt_pass_cnt=1.
